// File: rtl/bram_rd_pkg.sv
// Shared types and constants for the BRAM stream reader.
// The FIFO depth and the issue credit limit live here.
package bram_rd_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_e;

  localparam int FIFO_DEPTH   = 2;
  localparam int CREDIT_LIMIT = FIFO_DEPTH;

endpackage

// File: rtl/bram_rd_skid_fifo.sv
// Two-entry {last, data} FIFO that absorbs BRAM read latency.
// Outputs read as zero while the FIFO is empty.
module bram_rd_skid_fifo
  import bram_rd_pkg::*;
#(
  parameter int W = 256
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         last_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic         last_o,
  output logic [W-1:0] data_o,
  output logic [1:0]   count_o
);

  logic [W:0] mem_q [FIFO_DEPTH];
  logic       rd_q;
  logic       wr_q;
  logic [1:0] cnt_q;

  // Storage, pointers and occupancy; push and pop may coincide.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= {last_i, data_i};
        wr_q        <= ~wr_q;
      end
      if (pop_i) begin
        rd_q <= ~rd_q;
      end
      cnt_q <= cnt_q + 2'(push_i) - 2'(pop_i);
    end
  end

  assign valid_o = (cnt_q != 2'd0);
  assign {last_o, data_o} = valid_o ? mem_q[rd_q] : '0;
  assign count_o = cnt_q;

endmodule

// File: rtl/bram_stream_reader.sv
// Burst reader: BRAM read port to valid/ready stream with last flag.
// Define BRAM_RD_WRAP_EN for address wrap and no range check.
module bram_stream_reader
  import bram_rd_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 256,
  parameter int MEMSIZE    = 64,
  parameter int LEN_WIDTH  = 7
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  output logic                  req_err,
  output logic                  bram_en,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy
);

  localparam int SW = LEN_WIDTH + 1;

  rd_state_e             state_q;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [LEN_WIDTH-1:0]  rem_q;
  logic                  infl_q;
  logic                  infl_last_q;
  logic                  err_q;

  logic       accept;
  logic       pop;
  logic       issue;
  logic       issue_last;
  logic       in_range;
  logic [1:0] occ;
  logic [2:0] outstanding;

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid & req_ready;
  assign pop       = out_valid & out_ready;

`ifdef BRAM_RD_WRAP_EN
  assign in_range = 1'b1;
  assign req_err  = 1'b0;
`else
  logic [SW-1:0] end_w;
  assign end_w    = SW'(req_addr) + SW'(req_len);
  assign in_range = (end_w <= SW'(MEMSIZE));
  assign req_err  = err_q;
`endif

  assign outstanding = 3'(occ) + 3'(infl_q) - 3'(pop);
  assign issue       = (state_q == READ) &&
                       (outstanding < 3'(CREDIT_LIMIT));
  assign issue_last  = issue && (rem_q == LEN_WIDTH'(1));

  assign bram_en   = issue;
  assign bram_addr = ptr_q;

  // Request acceptance, read issue and the one-cycle error pulse.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      rem_q       <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      infl_q      <= issue;
      infl_last_q <= issue_last;
      err_q       <= accept & ~in_range;
      unique case (state_q)
        IDLE: begin
          if (accept && in_range && (req_len != '0)) begin
            state_q <= READ;
            ptr_q   <= req_addr;
            rem_q   <= req_len;
          end
        end
        READ: begin
          if (issue) begin
`ifdef BRAM_RD_WRAP_EN
            ptr_q <= (ptr_q == ADDR_WIDTH'(MEMSIZE - 1)) ?
                     '0 : ptr_q + 1'b1;
`else
            ptr_q <= ptr_q + 1'b1;
`endif
            rem_q <= rem_q - 1'b1;
            if (issue_last) begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  bram_rd_skid_fifo #(
    .W (DATA_WIDTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .push_i  (infl_q),
    .pop_i   (pop),
    .last_i  (infl_last_q),
    .data_i  (bram_dout),
    .valid_o (out_valid),
    .last_o  (out_last),
    .data_o  (out_data),
    .count_o (occ)
  );

  assign busy = (state_q != IDLE) | infl_q | (occ != 2'd0);

`ifndef BRAM_RD_WRAP_EN
`else
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader with a BRAM model and a
// queue-based reference checked every cycle on the falling edge.
module tb_bram_stream_reader;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [5:0]   req_addr = '0;
  logic [6:0]   req_len = '0;
  logic         req_err;
  logic         bram_en;
  logic [5:0]   bram_addr;
  logic [255:0] bram_dout = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [255:0] out_data;
  logic         out_last;
  logic         busy;

  int total = 0;
  int bad = 0;

  bram_stream_reader dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .req_err   (req_err),
    .bram_en   (bram_en),
    .bram_addr (bram_addr),
    .bram_dout (bram_dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  logic [255:0] mem [64];
  initial for (int i = 0; i < 64; i++) mem[i] = 256'(i);

  always @(posedge CLK) if (bram_en) bram_dout <= mem[bram_addr];

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [5:0]   exp_addr_q [$];
  logic [256:0] exp_word_q [$];
  logic [7:0]   cap_q [$];
  logic         cap_last_q [$];
  logic         err_exp = 1'b0;
  int issued = 0;
  int popped = 0;
  int err_cnt = 0;
  int en_cnt = 0;
  int ov_cnt = 0;
  int busy_cnt = 0;
  int acc_cyc = -1;
  int first_ov = -1;

  task automatic chk(input logic ok, input string name,
                     input logic [255:0] act,
                     input logic [255:0] req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic model_req(input logic [5:0] a,
                           input logic [6:0] l);
    int ad;
    logic wrap;
`ifdef BRAM_RD_WRAP_EN
    wrap = 1'b1;
`else
    wrap = 1'b0;
`endif
    if (l == 0) return;
    if (!wrap && (int'(a) + int'(l) > 64)) begin
      err_exp = 1'b1;
      return;
    end
    for (int k = 0; k < int'(l); k++) begin
      ad = (int'(a) + k) % 64;
      exp_addr_q.push_back(6'(ad));
      exp_word_q.push_back({(k == int'(l) - 1), mem[ad]});
    end
  endtask

  // Reference check of every output on the falling edge.
  always @(negedge CLK) begin
    logic [256:0] w;
    logic [5:0]   a;
    if (!RST_N) begin
      exp_addr_q.delete();
      exp_word_q.delete();
      err_exp = 1'b0;
      issued = 0;
      popped = 0;
    end else begin
      chk(req_err == err_exp, "req_err", 256'(req_err),
          256'(err_exp));
      err_exp = 1'b0;
      if (req_err) err_cnt++;
      if (busy) busy_cnt++;
      if (bram_en) begin
        en_cnt++;
        issued++;
        if (exp_addr_q.size() == 0) begin
          chk(1'b0, "bram_en_unexpected", 256'(bram_addr), 0);
        end else begin
          a = exp_addr_q.pop_front();
          chk(bram_addr == a, "bram_addr", 256'(bram_addr),
              256'(a));
        end
      end
      if (out_valid) begin
        ov_cnt++;
        if (first_ov < 0) first_ov = cyc;
        if (exp_word_q.size() == 0) begin
          chk(1'b0, "out_valid_unexpected", out_data, 0);
        end else if (out_ready) begin
          w = exp_word_q.pop_front();
          popped++;
          chk(out_data == w[255:0], "out_data", out_data,
              w[255:0]);
          chk(out_last == w[256], "out_last", 256'(out_last),
              256'(w[256]));
          cap_q.push_back(out_data[7:0]);
          cap_last_q.push_back(out_last);
        end
      end
      chk(issued - popped <= 2, "outstanding",
          256'(issued - popped), 2);
      if (req_valid && req_ready) begin
        acc_cyc = cyc;
        model_req(req_addr, req_len);
      end
    end
  end

  task automatic req(input logic [5:0] a, input logic [6:0] l);
    int n;
    n = 0;
    while (!req_ready && n < 200) begin
      @(posedge CLK); #1;
      n++;
    end
    if (!req_ready) chk(1'b0, "req_ready_timeout", 0, 1);
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = l;
    @(posedge CLK); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || exp_word_q.size() != 0) && n < 300) begin
      @(posedge CLK); #1;
      n++;
    end
    chk(!busy && exp_word_q.size() == 0, "idle_timeout",
        256'(busy), 0);
    repeat (2) @(posedge CLK);
    #1;
  endtask

  task automatic clear_cap();
    cap_q.delete();
    cap_last_q.delete();
    err_cnt = 0;
    en_cnt = 0;
    ov_cnt = 0;
    busy_cnt = 0;
    first_ov = -1;
  endtask

  task automatic check_seq(input string name, input int n,
                           input int base0, input int step_at,
                           input int base1);
    int v;
    chk(cap_q.size() == n, name, 256'(cap_q.size()), 256'(n));
    for (int i = 0; i < n && i < cap_q.size(); i++) begin
      v = (i < step_at) ? base0 + i : base1 + i - step_at;
      chk(cap_q[i] == 8'(v), name, 256'(cap_q[i]), 256'(v));
    end
  endtask

  task automatic check_outs_reset(input string tag);
    chk(req_ready == 1'b1, {tag, "_req_ready"},
        256'(req_ready), 1);
    chk(req_err == 1'b0, {tag, "_req_err"}, 256'(req_err), 0);
    chk(bram_en == 1'b0, {tag, "_bram_en"}, 256'(bram_en), 0);
    chk(bram_addr == 6'd0, {tag, "_bram_addr"},
        256'(bram_addr), 0);
    chk(out_valid == 1'b0, {tag, "_out_valid"},
        256'(out_valid), 0);
    chk(out_last == 1'b0, {tag, "_out_last"}, 256'(out_last), 0);
    chk(out_data == '0, {tag, "_out_data"}, out_data, 0);
    chk(busy == 1'b0, {tag, "_busy"}, 256'(busy), 0);
  endtask

  initial begin
    int n;
    #1;
    check_outs_reset("reset");
    repeat (3) @(posedge CLK);
    #3 RST_N = 1'b1;
    @(posedge CLK); #1;

    // 1: basic burst and latency
    clear_cap();
    req(6'd4, 7'd3);
    wait_idle();
    check_seq("t1_words", 3, 4, 3, 0);
    if (cap_last_q.size() == 3) begin
      chk(cap_last_q[2] && !cap_last_q[1] && !cap_last_q[0],
          "t1_last", 256'({cap_last_q[0], cap_last_q[1],
          cap_last_q[2]}), 256'(3'b001));
    end else begin
      chk(1'b0, "t1_last_count", 256'(cap_last_q.size()), 3);
    end
    chk(first_ov - acc_cyc == 3, "t1_latency",
        256'(first_ov - acc_cyc), 3);

    // 2: consumer stall mid-burst
    clear_cap();
    req(6'd0, 7'd8);
    repeat (3) @(posedge CLK);
    #1 out_ready = 1'b0;
    repeat (6) @(posedge CLK);
    #1 out_ready = 1'b1;
    wait_idle();
    check_seq("t2_words", 8, 0, 8, 0);

    // 3: back-to-back bursts
    clear_cap();
    req(6'd0, 7'd2);
    req(6'd10, 7'd2);
    wait_idle();
    check_seq("t3_words", 4, 0, 2, 10);
    if (cap_last_q.size() == 4) begin
      chk(cap_last_q[1] && cap_last_q[3] &&
          !cap_last_q[0] && !cap_last_q[2], "t3_last", 0, 0);
    end else begin
      chk(1'b0, "t3_last_count", 256'(cap_last_q.size()), 4);
    end

    // 4: range check or wrap
    clear_cap();
    req(6'd60, 7'd8);
    wait_idle();
`ifdef BRAM_RD_WRAP_EN
    chk(err_cnt == 0, "t4_err", 256'(err_cnt), 0);
    chk(en_cnt == 8, "t4_en", 256'(en_cnt), 8);
    check_seq("t4_words", 8, 60, 4, 0);
`else
    chk(err_cnt == 1, "t4_err", 256'(err_cnt), 1);
    chk(en_cnt == 0, "t4_en", 256'(en_cnt), 0);
    chk(ov_cnt == 0, "t4_ov", 256'(ov_cnt), 0);
`endif

    // 5: zero length
    clear_cap();
    req(6'd7, 7'd0);
    wait_idle();
    chk(busy_cnt == 0, "t5_busy", 256'(busy_cnt), 0);
    chk(ov_cnt == 0, "t5_ov", 256'(ov_cnt), 0);
    chk(err_cnt == 0, "t5_err", 256'(err_cnt), 0);
    chk(req_ready == 1'b1, "t5_ready", 256'(req_ready), 1);

    // 6: reset mid-burst, then a fresh request
    clear_cap();
    req(6'd0, 7'd8);
    n = 0;
    while (cap_q.size() < 2 && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
    chk(cap_q.size() == 2, "t6_pre", 256'(cap_q.size()), 2);
    #1 RST_N = 1'b0;
    #1;
    check_outs_reset("t6_rst");
    @(posedge CLK); @(posedge CLK);
    #3 RST_N = 1'b1;
    @(posedge CLK); #1;
    clear_cap();
    req(6'd5, 7'd1);
    wait_idle();
    check_seq("t6_words", 1, 5, 1, 0);
    if (cap_last_q.size() == 1) begin
      chk(cap_last_q[0], "t6_last", 256'(cap_last_q[0]), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: time %0t limit 200000", $time);
    $fatal(1);
  end

endmodule
